// File: rtl/w_grf_pkg.sv
// Shared ISA constants and the write-back data select encoding for the W stage.
// Combinational use only; holds no state.
// Imported by the W-stage decoder, the register file top and the hazard unit.
package w_grf_pkg;

    // Primary opcodes (instr[31:26])
    localparam logic [5:0] OP_SPECIAL = 6'b000000;
    localparam logic [5:0] OP_REGIMM  = 6'b000001;
    localparam logic [5:0] OP_JAL     = 6'b000011;
    localparam logic [5:0] OP_ADDI    = 6'b001000;
    localparam logic [5:0] OP_ADDIU   = 6'b001001;
    localparam logic [5:0] OP_SLTI    = 6'b001010;
    localparam logic [5:0] OP_ANDI    = 6'b001100;
    localparam logic [5:0] OP_ORI     = 6'b001101;
    localparam logic [5:0] OP_LUI     = 6'b001111;
    localparam logic [5:0] OP_LB      = 6'b100000;
    localparam logic [5:0] OP_LH      = 6'b100001;
    localparam logic [5:0] OP_LW      = 6'b100011;
    localparam logic [5:0] OP_LBU     = 6'b100100;
    localparam logic [5:0] OP_LHU     = 6'b100101;

    // SPECIAL function codes (instr[5:0])
    localparam logic [5:0] FN_JALR = 6'b001001;
    localparam logic [5:0] FN_MOVZ = 6'b001010;
    localparam logic [5:0] FN_MFHI = 6'b010000;
    localparam logic [5:0] FN_MFLO = 6'b010010;
    localparam logic [5:0] FN_ADD  = 6'b100000;
    localparam logic [5:0] FN_ADDU = 6'b100001;
    localparam logic [5:0] FN_SUB  = 6'b100010;
    localparam logic [5:0] FN_SUBU = 6'b100011;
    localparam logic [5:0] FN_AND  = 6'b100100;
    localparam logic [5:0] FN_OR   = 6'b100101;
    localparam logic [5:0] FN_SLT  = 6'b101010;
    localparam logic [5:0] FN_SLTU = 6'b101011;

    // REGIMM rt code for bgezal, and architectural register indices
    localparam logic [4:0] RT_BGEZAL = 5'b10001;
    localparam logic [4:0] REG_ZERO  = 5'd0;
    localparam logic [4:0] REG_RA    = 5'd31;

    // Source of the write-back value
    typedef enum logic [1:0] {
        SEL_ALU = 2'd0,
        SEL_DM  = 2'd1,
        SEL_MD  = 2'd2,
        SEL_PC8 = 2'd3
    } wdata_sel_e;

endpackage

// File: rtl/w_grf_dec.sv
// W-stage write-back decoder: instruction -> (write enable, destination, data source).
// Purely combinational, zero latency.
// No handshake; enable already excludes register 0 and untaken conditional writes.
import w_grf_pkg::*;

module w_grf_dec (
    input  logic [31:0] instr,
    input  logic        b_j,
    input  logic        alu_zero,
    output logic        wr_en,
    output logic [4:0]  wr_addr,
    output wdata_sel_e  wdata_sel
);

    logic [5:0] op;
    logic [5:0] funct;
    logic [4:0] rt;
    logic [4:0] rd;
    logic       en_raw;
    logic [4:0] dst;
    logic       unused_fields;

    assign op    = instr[31:26];
    assign rt    = instr[20:16];
    assign rd    = instr[15:11];
    assign funct = instr[5:0];
    assign unused_fields = ^{instr[25:21], instr[10:6]};

    // Classify the instruction into destination and data source
    always_comb begin
        en_raw    = 1'b0;
        dst       = REG_ZERO;
        wdata_sel = SEL_ALU;
        case (op)
            OP_SPECIAL: begin
                case (funct)
                    FN_ADD, FN_ADDU, FN_SUB, FN_SUBU,
                    FN_AND, FN_OR, FN_SLT, FN_SLTU: begin
                        en_raw = 1'b1;
                        dst    = rd;
                    end
                    FN_MOVZ: begin
                        en_raw = alu_zero;
                        dst    = rd;
                    end
                    FN_MFHI, FN_MFLO: begin
                        en_raw    = 1'b1;
                        dst       = rd;
                        wdata_sel = SEL_MD;
                    end
                    FN_JALR: begin
                        en_raw    = 1'b1;
                        dst       = rd;
                        wdata_sel = SEL_PC8;
                    end
                    default: ;
                endcase
            end
            OP_ADDI, OP_ADDIU, OP_SLTI, OP_ANDI, OP_ORI, OP_LUI: begin
                en_raw = 1'b1;
                dst    = rt;
            end
            OP_LB, OP_LH, OP_LW, OP_LBU, OP_LHU: begin
                en_raw    = 1'b1;
                dst       = rt;
                wdata_sel = SEL_DM;
            end
            OP_JAL: begin
                en_raw    = 1'b1;
                dst       = REG_RA;
                wdata_sel = SEL_PC8;
            end
            OP_REGIMM: begin
                if (rt == RT_BGEZAL) begin
                    en_raw    = b_j;
                    dst       = REG_RA;
                    wdata_sel = SEL_PC8;
                end
            end
            default: ;
        endcase
    end

    // Writes to $0 are dropped entirely; idle destination reads as 0
    assign wr_en   = en_raw && (dst != REG_ZERO);
    assign wr_addr = wr_en ? dst : REG_ZERO;

endmodule

// File: rtl/w_grf.sv
// Write-back stage and 32x32 GPR file with two combinational read ports.
// Commit at the rising edge ending the W cycle; reads are zero latency with write-through bypass.
// No backpressure: the W stage never stalls and every cycle may commit.
import w_grf_pkg::*;

module w_grf (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] w_pc,
    input  logic [31:0] w_instr,
    input  logic [31:0] w_alu,
    input  logic [31:0] w_dm,
    input  logic [31:0] w_md,
    input  logic        w_b_j,
    input  logic        w_alu_zero,
    input  logic [4:0]  rs_addr,
    input  logic [4:0]  rt_addr,
    output logic [31:0] rs_data,
    output logic [31:0] rt_data,
    output logic        w_wr_en,
    output logic [4:0]  w_wr_addr,
    output logic [31:0] w_wr_data
);

    // $0 is not stored; only indices 1..31 hold state
    logic [31:0] regs_q [1:31];
    logic [31:0] regs_d [1:31];
    wdata_sel_e  wdata_sel;
    logic [31:0] sel_data;

    w_grf_dec u_dec (
        .instr     (w_instr),
        .b_j       (w_b_j),
        .alu_zero  (w_alu_zero),
        .wr_en     (w_wr_en),
        .wr_addr   (w_wr_addr),
        .wdata_sel (wdata_sel)
    );

    // Write-back data mux; link address wraps modulo 2^32
    always_comb begin
        case (wdata_sel)
            SEL_ALU: sel_data = w_alu;
            SEL_DM:  sel_data = w_dm;
            SEL_MD:  sel_data = w_md;
            default: sel_data = w_pc + 32'd8;
        endcase
    end

    assign w_wr_data = w_wr_en ? sel_data : 32'd0;

    // Next array contents: the single decoded write lands on its index
    always_comb begin
        regs_d = regs_q;
        for (int i = 1; i < 32; i++) begin
            if (w_wr_en && (w_wr_addr == 5'(i))) begin
                regs_d[i] = w_wr_data;
            end
        end
    end

    // Register array; reset clears asynchronously and blocks any commit
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 1; i < 32; i++) begin
                regs_q[i] <= 32'd0;
            end
        end else begin
            regs_q <= regs_d;
        end
    end

    // Read ports: $0 is hardwired, a same-cycle write is forwarded
    always_comb begin
        rs_data = 32'd0;
        rt_data = 32'd0;
        if (rs_addr != REG_ZERO) begin
            rs_data = (w_wr_en && (rs_addr == w_wr_addr)) ? w_wr_data : regs_q[rs_addr];
        end
        if (rt_addr != REG_ZERO) begin
            rt_data = (w_wr_en && (rt_addr == w_wr_addr)) ? w_wr_data : regs_q[rt_addr];
        end
    end

endmodule
